// File: rtl/bus_pkg.sv
// Shared types and constants for the 68k-side bus controller.
package bus_pkg;

  // Bus cycle states seen by the controller FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    ACK  = 2'd2,
    BERR = 2'd3
  } bus_state_t;

  // Width of the per-region fixed wait-state counter
  localparam int WAIT_W = 4;

  // Width of the SEL-state timeout counter
  localparam int TMO_W = 8;

  // Index width for a slave count, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/region_decoder.sv
// Combinational priority decoder: matches an address against the
// programmable base/mask regions; the lowest matching index wins.
module region_decoder
  import bus_pkg::*;
#(
  parameter int                         N_SLAVES    = 4,
  parameter int                         ADDR_W      = 32,
  parameter int                         IDX_W       = idx_width(N_SLAVES),
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic                hit,
  output logic [N_SLAVES-1:0] onehot,
  output logic [IDX_W-1:0]    idx
);

  // Scan from the highest index down so the lowest matching region is the
  // one left standing when regions overlap.
  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit       = 1'b1;
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_controller.sv
// 68k-side bus controller: region decode, one-hot slave selects, per-region
// wait states with optional slave-ready, DTACK/BERR handshake and a
// registered read-data mux back to the CPU.
module bus_controller
  import bus_pkg::*;
#(
  parameter int                         N_SLAVES    = 4,
  parameter int                         ADDR_W      = 32,
  parameter int                         DATA_W      = 16,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_MASK = '0,
  parameter logic [N_SLAVES*WAIT_W-1:0] REGION_WAIT = '0,
  parameter logic [N_SLAVES-1:0]        REGION_RDY  = '0,
  parameter int                         TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic                       cpu_as,
  input  logic                       cpu_write,
  input  logic                       cpu_uds,
  input  logic                       cpu_lds,
  input  logic [DATA_W-1:0]          cpu_dataout,
  output logic [DATA_W-1:0]          cpu_datain,
  output logic                       cpu_dtack,
  output logic                       cpu_berr,
  output logic [N_SLAVES-1:0]        slv_sel,
  output logic                       slv_write,
  output logic [1:0]                 slv_be,
  output logic [DATA_W-1:0]          slv_wdata,
  input  logic [N_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [N_SLAVES-1:0]        slv_ready
);

  localparam int IDX_W = idx_width(N_SLAVES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  bus_state_t          state;
  bus_state_t          next_state;

  logic                dec_hit;
  logic [N_SLAVES-1:0] dec_onehot;
  logic [IDX_W-1:0]    dec_idx;

  logic [IDX_W-1:0]    sel_idx;
  logic [N_SLAVES-1:0] sel_oh;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                write_q;
  logic [1:0]          be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                rdy_ok;
  logic                sel_done;
  logic                decode_go;

  region_decoder #(
    .N_SLAVES    (N_SLAVES),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_region_decoder (
    .addr   (cpu_addr),
    .hit    (dec_hit),
    .onehot (dec_onehot),
    .idx    (dec_idx)
  );

  // State register; reset forces an immediate return to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an address strobe drop in SEL aborts ahead of
  // completion, and completion wins over a same-cycle timeout.
  always_comb begin
    rdy_ok     = !REGION_RDY[sel_idx] || slv_ready[sel_idx];
    sel_done   = (wait_cnt == '0) && rdy_ok;
    decode_go  = (state == IDLE) && cpu_as && dec_hit;
    next_state = state;
    case (state)
      IDLE: begin
        if (cpu_as) begin
          next_state = dec_hit ? SEL : BERR;
        end
      end
      SEL: begin
        if (!cpu_as) begin
          next_state = IDLE;
        end else if (sel_done) begin
          next_state = ACK;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = BERR;
        end
      end
      ACK, BERR: begin
        if (!cpu_as) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latches, counters and read capture; the transfer attributes are frozen
  // at decode so they stay stable for the whole time a select is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_idx  <= '0;
      sel_oh   <= '0;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
      write_q  <= 1'b0;
      be_q     <= 2'b00;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (decode_go) begin
        sel_idx  <= dec_idx;
        sel_oh   <= dec_onehot;
        wait_cnt <= REGION_WAIT[dec_idx*WAIT_W +: WAIT_W];
        tmo_cnt  <= '0;
        write_q  <= cpu_write;
        be_q     <= {cpu_uds, cpu_lds};
        wdata_q  <= cpu_dataout;
      end else if (state == SEL) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (wait_cnt != '0) begin
          wait_cnt <= wait_cnt - 1'b1;
        end
        if (next_state != SEL) begin
          sel_oh <= '0;
        end
        if ((next_state == ACK) && !write_q) begin
          rdata_q <= slv_rdata[sel_idx*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign cpu_dtack  = (state == ACK);
  assign cpu_berr   = (state == BERR);
  assign cpu_datain = rdata_q;
  assign slv_sel    = sel_oh;
  assign slv_write  = write_q;
  assign slv_be     = be_q;
  assign slv_wdata  = wdata_q;

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: directed timing checks plus a
// scoreboard of expected DTACK/BERR completions.
module tb_bus_controller;

  localparam int N_SLAVES = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 16;

  logic                       clk;
  logic                       rst;
  logic [ADDR_W-1:0]          cpu_addr;
  logic                       cpu_as;
  logic                       cpu_write;
  logic                       cpu_uds;
  logic                       cpu_lds;
  logic [DATA_W-1:0]          cpu_dataout;
  logic [DATA_W-1:0]          cpu_datain;
  logic                       cpu_dtack;
  logic                       cpu_berr;
  logic [N_SLAVES-1:0]        slv_sel;
  logic                       slv_write;
  logic [1:0]                 slv_be;
  logic [DATA_W-1:0]          slv_wdata;
  logic [N_SLAVES*DATA_W-1:0] slv_rdata;
  logic [N_SLAVES-1:0]        slv_ready;

  typedef struct {
    bit          isBerr;
    logic [15:0] data;
  } expect_t;

  expect_t sbQueue[$];

  int checkCount = 0;
  int passCount  = 0;
  logic [15:0] lastRead = 16'h0000;
  logic prevDtack = 1'b0;
  logic prevBerr  = 1'b0;

  bus_controller #(
    .N_SLAVES    (N_SLAVES),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .REGION_BASE ({32'h0030_0000, 32'h0020_0000, 32'h0010_0000, 32'h0000_0000}),
    .REGION_MASK ({32'h00FF_0000, 32'h00FF_0000, 32'h00FF_0000, 32'h00FF_0000}),
    .REGION_WAIT ({4'd1, 4'd0, 4'd3, 4'd0}),
    .REGION_RDY  (4'b0100),
    .TIMEOUT     (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_as      (cpu_as),
    .cpu_write   (cpu_write),
    .cpu_uds     (cpu_uds),
    .cpu_lds     (cpu_lds),
    .cpu_dataout (cpu_dataout),
    .cpu_datain  (cpu_datain),
    .cpu_dtack   (cpu_dtack),
    .cpu_berr    (cpu_berr),
    .slv_sel     (slv_sel),
    .slv_write   (slv_write),
    .slv_be      (slv_be),
    .slv_wdata   (slv_wdata),
    .slv_rdata   (slv_rdata),
    .slv_ready   (slv_ready)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Start a bus cycle on the falling edge; the next rising edge decodes it
  task automatic applyStimulus(input logic [31:0] addr, input bit wr, input logic [1:0] be,
                               input logic [15:0] data);
    @(negedge clk);
    cpu_addr    = addr;
    cpu_write   = wr;
    cpu_uds     = be[1];
    cpu_lds     = be[0];
    cpu_dataout = data;
    cpu_as      = 1'b1;
  endtask

  // Drop the strobe and confirm the handshake outputs release a cycle later
  task automatic endCycle(input string tag);
    cpu_as = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_dtack_release"}, 32'(cpu_dtack), 32'd0);
    checkOutput({tag, "_berr_release"}, 32'(cpu_berr), 32'd0);
  endtask

  // Full mapped access with its select window and acknowledge timing
  task automatic runAccess(input string tag, input logic [31:0] addr, input bit wr,
                           input logic [15:0] wdata, input logic [3:0] expSel,
                           input int expWait, input logic [15:0] rdData);
    expect_t e;
    if (!wr) begin
      lastRead = rdData;
    end
    e.isBerr = 1'b0;
    e.data   = lastRead;
    applyStimulus(addr, wr, 2'b11, wdata);
    sbQueue.push_back(e);
    for (int k = 0; k <= expWait; k++) begin
      @(negedge clk);
      checkOutput({tag, "_sel"}, 32'(slv_sel), 32'(expSel));
      checkOutput({tag, "_early_dtack"}, 32'(cpu_dtack), 32'd0);
      checkOutput({tag, "_slv_write"}, 32'(slv_write), 32'(wr));
      if (wr) begin
        checkOutput({tag, "_wdata"}, 32'(slv_wdata), 32'(wdata));
        checkOutput({tag, "_be"}, 32'(slv_be), 32'd3);
      end
    end
    @(negedge clk);
    checkOutput({tag, "_dtack"}, 32'(cpu_dtack), 32'd1);
    checkOutput({tag, "_sel_clear"}, 32'(slv_sel), 32'd0);
    endCycle(tag);
  endtask

  // Scoreboard monitor: each rising DTACK or BERR consumes one expectation
  always @(negedge clk) begin
    expect_t e;
    if (!rst) begin
      if (cpu_dtack || cpu_berr) begin
        checkOutput("dtack_berr_exclusive", 32'(cpu_dtack && cpu_berr), 32'd0);
      end
      if ((cpu_dtack && !prevDtack) || (cpu_berr && !prevBerr)) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("sb_kind_berr", 32'(cpu_berr), 32'(e.isBerr));
          if (!e.isBerr) begin
            checkOutput("sb_datain", 32'(cpu_datain), 32'(e.data));
          end
        end
      end
    end
    prevDtack = cpu_dtack;
    prevBerr  = cpu_berr;
  end

  initial begin
    expect_t e;
    int selCycles;
    bit seenBerr;

    rst         = 1'b1;
    cpu_addr    = '0;
    cpu_as      = 1'b0;
    cpu_write   = 1'b0;
    cpu_uds     = 1'b0;
    cpu_lds     = 1'b0;
    cpu_dataout = '0;
    slv_ready   = '0;
    slv_rdata   = '0;
    slv_rdata[0*16 +: 16] = 16'hBEEF;
    slv_rdata[1*16 +: 16] = 16'h1111;
    slv_rdata[2*16 +: 16] = 16'hCAFE;
    slv_rdata[3*16 +: 16] = 16'h5A5A;

    repeat (3) @(negedge clk);
    checkOutput("reset_sel", 32'(slv_sel), 32'd0);
    checkOutput("reset_dtack", 32'(cpu_dtack), 32'd0);
    checkOutput("reset_berr", 32'(cpu_berr), 32'd0);
    checkOutput("reset_datain", 32'(cpu_datain), 32'd0);
    checkOutput("reset_wdata", 32'({slv_write, slv_be, slv_wdata}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] region 0 read, no wait states");
    runAccess("rd0", 32'h0000_0010, 1'b0, 16'h0000, 4'b0001, 0, 16'hBEEF);

    $display("[TB] region 1 write, three wait states");
    runAccess("wr1", 32'h0010_0004, 1'b1, 16'h1234, 4'b0010, 3, 16'h0000);

    $display("[TB] region 2 read, ready raised after six select cycles");
    lastRead = 16'hCAFE;
    e.isBerr = 1'b0;
    e.data   = 16'hCAFE;
    applyStimulus(32'h0020_0000, 1'b0, 2'b11, 16'h0000);
    sbQueue.push_back(e);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("rdy_sel", 32'(slv_sel), 32'b0100);
      checkOutput("rdy_early_dtack", 32'(cpu_dtack), 32'd0);
    end
    slv_ready[2] = 1'b1;
    @(negedge clk);
    checkOutput("rdy_dtack", 32'(cpu_dtack), 32'd1);
    checkOutput("rdy_sel_clear", 32'(slv_sel), 32'd0);
    slv_ready[2] = 1'b0;
    endCycle("rdy");

    $display("[TB] region 2 read, ready never arrives");
    e.isBerr = 1'b1;
    e.data   = 16'h0000;
    applyStimulus(32'h0020_0002, 1'b0, 2'b01, 16'h0000);
    sbQueue.push_back(e);
    selCycles = 0;
    seenBerr  = 1'b0;
    for (int k = 0; k < 300 && !seenBerr; k++) begin
      @(negedge clk);
      if (cpu_berr) begin
        seenBerr = 1'b1;
      end else if (slv_sel == 4'b0100) begin
        selCycles++;
      end
    end
    checkOutput("tmo_berr", 32'(seenBerr), 32'd1);
    checkOutput("tmo_sel_cycles", 32'(selCycles), 32'd255);
    checkOutput("tmo_sel_clear", 32'(slv_sel), 32'd0);
    endCycle("tmo");

    $display("[TB] unmapped read");
    applyStimulus(32'h0090_0000, 1'b0, 2'b11, 16'h0000);
    sbQueue.push_back(e);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("unmap_berr", 32'(cpu_berr), 32'd1);
      checkOutput("unmap_sel", 32'(slv_sel), 32'd0);
    end
    endCycle("unmap");

    $display("[TB] strobe dropped during wait states");
    applyStimulus(32'h0010_0000, 1'b1, 2'b10, 16'hAAAA);
    @(negedge clk);
    checkOutput("abort_sel", 32'(slv_sel), 32'b0010);
    cpu_as = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("abort_sel_clear", 32'(slv_sel), 32'd0);
      checkOutput("abort_no_resp", 32'({cpu_dtack, cpu_berr}), 32'd0);
    end
    runAccess("after_abort", 32'h0030_0000, 1'b0, 16'h0000, 4'b1000, 1, 16'h5A5A);

    $display("[TB] reset asserted during select");
    applyStimulus(32'h0010_0000, 1'b1, 2'b11, 16'h7777);
    @(negedge clk);
    checkOutput("mid_rst_sel", 32'(slv_sel), 32'b0010);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_sel_clear", 32'(slv_sel), 32'd0);
    checkOutput("mid_rst_outputs", 32'({cpu_dtack, cpu_berr, slv_write, slv_be, slv_wdata}), 32'd0);
    checkOutput("mid_rst_datain", 32'(cpu_datain), 32'd0);
    @(negedge clk);
    cpu_as = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    slv_rdata[0*16 +: 16] = 16'h1357;
    runAccess("post_rst", 32'h0000_0020, 1'b0, 16'h0000, 4'b0001, 0, 16'h1357);

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
